// File: rtl/ihp13_sram_bist_pkg.sv
// rtl/ihp13_sram_bist_pkg.sv - March C- operation/element definitions for the SRAM BIST engine
// Contents: march_op_e, march_elem_t, the six-element MarchCMinus table,
// the error counter width and small op-decoding helpers.
package ihp13_sram_bist_pkg;

  typedef enum logic [1:0] {
    R0 = 2'd0,
    R1 = 2'd1,
    W0 = 2'd2,
    W1 = 2'd3
  } march_op_e;

  // op[0] is issued first; op[1] is only used when op_cnt == 2.
  typedef struct packed {
    logic                dir_down;
    logic [1:0]          op_cnt;
    march_op_e [1:0]     op;
  } march_elem_t;

  localparam int NumMarchElems = 6;
  localparam int ErrCntWidth   = 16;

  // Fields: '{dir_down, op_cnt, '{op[1], op[0]}}
  localparam march_elem_t MarchCMinus [NumMarchElems] = '{
    '{1'b0, 2'd1, '{W0, W0}},  // E0 up(w0)
    '{1'b0, 2'd2, '{W1, R0}},  // E1 up(r0,w1)
    '{1'b0, 2'd2, '{W0, R1}},  // E2 up(r1,w0)
    '{1'b1, 2'd2, '{W1, R0}},  // E3 down(r0,w1)
    '{1'b1, 2'd2, '{W0, R1}},  // E4 down(r1,w0)
    '{1'b0, 2'd1, '{R0, R0}}   // E5 up(r0)
  };

  function automatic logic op_is_read(input march_op_e op);
    return (op == R0) || (op == R1);
  endfunction

  function automatic logic op_is_one(input march_op_e op);
    return (op == R1) || (op == W1);
  endfunction

endpackage

// File: rtl/ihp13_sram_bist_cmp.sv
// rtl/ihp13_sram_bist_cmp.sv - Registered read-compare pipeline for the SRAM BIST engine
// Ports:
//   clk_i, rst_i    clock, asynchronous active-high reset
//   rd_issue_i      a read is being issued this cycle
//   exp_data_i      expected word for that read
//   addr_i          address of that read
//   rd_data_i       macro read data (valid one cycle after the read)
//   mismatch_o      one-cycle pulse, the cycle after the data returned
//   fail_addr_o     address belonging to the mismatch pulse
module ihp13_sram_bist_cmp #(
  parameter int DataWidth = 64,
  parameter int AddrWidth = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rd_issue_i,
  input  logic [DataWidth-1:0] exp_data_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [DataWidth-1:0] rd_data_i,
  output logic                 mismatch_o,
  output logic [AddrWidth-1:0] fail_addr_o
);

  logic                 pend_q, pend_d;
  logic [DataWidth-1:0] exp_q, exp_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic                 mis_q, mis_d;
  logic [AddrWidth-1:0] mis_addr_q, mis_addr_d;

  always_comb begin
    pend_d     = rd_issue_i;
    exp_d      = rd_issue_i ? exp_data_i : exp_q;
    addr_d     = rd_issue_i ? addr_i : addr_q;
    // pend_q gates the compare so undriven read data never counts.
    mis_d      = pend_q && (rd_data_i != exp_q);
    mis_addr_d = pend_q ? addr_q : mis_addr_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q     <= 1'b0;
      exp_q      <= '0;
      addr_q     <= '0;
      mis_q      <= 1'b0;
      mis_addr_q <= '0;
    end else begin
      pend_q     <= pend_d;
      exp_q      <= exp_d;
      addr_q     <= addr_d;
      mis_q      <= mis_d;
      mis_addr_q <= mis_addr_d;
    end
  end

  assign mismatch_o  = mis_q;
  assign fail_addr_o = mis_addr_q;

endmodule

// File: rtl/ihp13_sram_bist.sv
// rtl/ihp13_sram_bist.sv - March C- BIST engine driving the A_BIST_* port group of one IHP13 SRAM cut
// Optional build macro: IHP13_SRAM_BIST_DIAG_EN (count all mismatches, never abort).
// Ports:
//   clk_i, rst_i        macro clock, asynchronous active-high reset
//   start_i             start request, sampled in IDLE only
//   busy_o              RUN or DRAIN
//   done_o, fail_o      sticky status, cleared by the next start
//   fail_addr_o         first failing address
//   err_cnt_o           mismatch count
//   bist_*_o            A_BIST_EN/MEN/WEN/REN/ADDR/DIN/BM
//   bist_dout_i         A_DOUT
module ihp13_sram_bist
  import ihp13_sram_bist_pkg::*;
#(
  parameter int NumWords  = 256,
  parameter int DataWidth = 64,
  parameter int AddrWidth = $clog2(NumWords)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   fail_o,
  output logic [AddrWidth-1:0]   fail_addr_o,
  output logic [ErrCntWidth-1:0] err_cnt_o,
  output logic                   bist_en_o,
  output logic                   bist_men_o,
  output logic                   bist_wen_o,
  output logic                   bist_ren_o,
  output logic [AddrWidth-1:0]   bist_addr_o,
  output logic [DataWidth-1:0]   bist_din_o,
  output logic [DataWidth-1:0]   bist_bm_o,
  input  logic [DataWidth-1:0]   bist_dout_i
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam logic [AddrWidth-1:0]   LastAddr = AddrWidth'(NumWords - 1);
  localparam logic [2:0]             LastElem = 3'(NumMarchElems - 1);
  localparam logic [ErrCntWidth-1:0] ErrMax   = {ErrCntWidth{1'b1}};

`ifdef IHP13_SRAM_BIST_DIAG_EN
  localparam bit StopOnFail = 1'b0;
`else
  localparam bit StopOnFail = 1'b1;
`endif

  logic [1:0]             state_q, state_d;
  logic [2:0]             elem_q, elem_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic                   op_idx_q, op_idx_d;
  logic                   done_q, done_d;
  logic                   fail_q, fail_d;
  logic [AddrWidth-1:0]   fail_addr_q, fail_addr_d;
  logic [ErrCntWidth-1:0] err_cnt_q, err_cnt_d;

  march_elem_t          cur_elem;
  march_op_e            cur_op;
  logic [2:0]           next_elem;
  logic                 op_read, op_one, last_op, last_addr, issue;
  logic [DataWidth-1:0] pattern;
  logic                 cmp_mismatch;
  logic [AddrWidth-1:0] cmp_fail_addr;

  always_comb begin
    cur_elem  = MarchCMinus[elem_q];
    cur_op    = cur_elem.op[op_idx_q];
    next_elem = elem_q + 3'd1;
    op_read   = op_is_read(cur_op);
    op_one    = op_is_one(cur_op);
    pattern   = {DataWidth{op_one}};
    last_op   = ({1'b0, op_idx_q} == (cur_elem.op_cnt - 2'd1));
    // Terminal-address compare instead of counter wrap.
    last_addr = cur_elem.dir_down ? (addr_q == '0) : (addr_q == LastAddr);
  end

  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    addr_d      = addr_q;
    op_idx_d    = op_idx_q;
    done_d      = done_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    err_cnt_d   = err_cnt_q;
    issue       = 1'b0;

    // A mismatch can surface in RUN, DRAIN or DONE (the last read's compare
    // lands in DONE). Stop-on-fail keeps only the first one.
    if (cmp_mismatch) begin
      if (!fail_q) begin
        fail_d      = 1'b1;
        fail_addr_d = cmp_fail_addr;
      end
      if ((!StopOnFail || !fail_q) && (err_cnt_q != ErrMax)) begin
        err_cnt_d = err_cnt_q + ErrCntWidth'(1);
      end
    end

    case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d     = StRun;
          elem_d      = '0;
          addr_d      = '0;
          op_idx_d    = 1'b0;
          done_d      = 1'b0;
          fail_d      = 1'b0;
          fail_addr_d = '0;
          err_cnt_d   = '0;
        end
      end
      StRun: begin
        if (StopOnFail && cmp_mismatch) begin
          // Suppress this cycle's op; only the op issued while the failing
          // read's data was returning has gone out.
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          issue = 1'b1;
          if (!last_op) begin
            op_idx_d = 1'b1;
          end else begin
            op_idx_d = 1'b0;
            if (!last_addr) begin
              addr_d = cur_elem.dir_down ? (addr_q - AddrWidth'(1)) : (addr_q + AddrWidth'(1));
            end else if (elem_q == LastElem) begin
              state_d = StDrain;
            end else begin
              elem_d = next_elem;
              addr_d = MarchCMinus[next_elem].dir_down ? LastAddr : '0;
            end
          end
        end
      end
      StDrain: begin
        state_d = StDone;
        done_d  = 1'b1;
      end
      default: begin
        // DONE: single cycle, start_i ignored.
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      elem_q      <= '0;
      addr_q      <= '0;
      op_idx_q    <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      addr_q      <= addr_d;
      op_idx_q    <= op_idx_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  ihp13_sram_bist_cmp #(
    .DataWidth (DataWidth),
    .AddrWidth (AddrWidth)
  ) u_cmp (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rd_issue_i  (issue && op_read),
    .exp_data_i  (pattern),
    .addr_i      (addr_q),
    .rd_data_i   (bist_dout_i),
    .mismatch_o  (cmp_mismatch),
    .fail_addr_o (cmp_fail_addr)
  );

  assign busy_o      = (state_q == StRun) || (state_q == StDrain);
  assign done_o      = done_q;
  assign fail_o      = fail_q;
  assign fail_addr_o = fail_addr_q;
  assign err_cnt_o   = err_cnt_q;

  assign bist_en_o   = issue;
  assign bist_men_o  = issue;
  assign bist_wen_o  = issue && !op_read;
  assign bist_ren_o  = issue && op_read;
  assign bist_addr_o = issue ? addr_q : '0;
  assign bist_din_o  = issue ? pattern : '0;
  assign bist_bm_o   = {DataWidth{issue}};

endmodule

// File: tb/tb_ihp13_sram_bist.sv
// tb/tb_ihp13_sram_bist.sv - Scoreboard bench for ihp13_sram_bist with a faultable SRAM model
module tb_ihp13_sram_bist;

  localparam int NumWords  = 256;
  localparam int DataWidth = 64;
  localparam int AddrWidth = 8;
  localparam int RunCycles = 10 * NumWords;
  localparam int Budget    = RunCycles + 50;

  logic                 clk = 1'b0;
  logic                 rst_i;
  logic                 start_i;
  logic                 busy_o, done_o, fail_o;
  logic [AddrWidth-1:0] fail_addr_o;
  logic [15:0]          err_cnt_o;
  logic                 bist_en_o, bist_men_o, bist_wen_o, bist_ren_o;
  logic [AddrWidth-1:0] bist_addr_o;
  logic [DataWidth-1:0] bist_din_o, bist_bm_o, bist_dout_i;

  always #5 clk = ~clk;

  ihp13_sram_bist #(.NumWords(NumWords), .DataWidth(DataWidth)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .fail_o      (fail_o),
    .fail_addr_o (fail_addr_o),
    .err_cnt_o   (err_cnt_o),
    .bist_en_o   (bist_en_o),
    .bist_men_o  (bist_men_o),
    .bist_wen_o  (bist_wen_o),
    .bist_ren_o  (bist_ren_o),
    .bist_addr_o (bist_addr_o),
    .bist_din_o  (bist_din_o),
    .bist_bm_o   (bist_bm_o),
    .bist_dout_i (bist_dout_i)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- SRAM model with fault injection ----------------
  // 0 none, 1 SA0 bit5 @0x12, 2 write-1 @0x40 flips 0x3F bit0, 3 SA1 bit3 @0x00/0xFF
  int fault_mode = 0;
  logic [DataWidth-1:0] mem [NumWords];

  function automatic logic [DataWidth-1:0] apply_fault(input int a, input logic [DataWidth-1:0] v);
    logic [DataWidth-1:0] r;
    r = v;
    if (fault_mode == 1 && a == 'h12) r[5] = 1'b0;
    if (fault_mode == 3 && (a == 'h00 || a == 'hFF)) r[3] = 1'b1;
    return r;
  endfunction

  always @(posedge clk) begin
    if (bist_en_o && bist_men_o) begin
      if (bist_wen_o) begin
        mem[bist_addr_o] <= apply_fault(int'(bist_addr_o),
                                        (mem[bist_addr_o] & ~bist_bm_o) | (bist_din_o & bist_bm_o));
        if (fault_mode == 2 && bist_addr_o == 8'h40 && bist_din_o[0])
          mem[8'h3F][0] <= ~mem[8'h3F][0];
      end
      if (bist_ren_o) bist_dout_i <= apply_fault(int'(bist_addr_o), mem[bist_addr_o]);
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic                 wr;
    logic [AddrWidth-1:0] addr;
    logic                 one;
  } op_t;

  op_t sb[$];

  function automatic op_t mk(input logic wr, input int a, input logic one);
    op_t o;
    o.wr   = wr;
    o.addr = AddrWidth'(a);
    o.one  = one;
    return o;
  endfunction

  // Expected March C- op stream, written out element by element.
  task automatic build_sb();
    sb.delete();
    for (int a = 0; a < NumWords; a++) sb.push_back(mk(1'b1, a, 1'b0));
    for (int a = 0; a < NumWords; a++) begin sb.push_back(mk(1'b0, a, 1'b0)); sb.push_back(mk(1'b1, a, 1'b1)); end
    for (int a = 0; a < NumWords; a++) begin sb.push_back(mk(1'b0, a, 1'b1)); sb.push_back(mk(1'b1, a, 1'b0)); end
    for (int a = NumWords - 1; a >= 0; a--) begin sb.push_back(mk(1'b0, a, 1'b0)); sb.push_back(mk(1'b1, a, 1'b1)); end
    for (int a = NumWords - 1; a >= 0; a--) begin sb.push_back(mk(1'b0, a, 1'b1)); sb.push_back(mk(1'b1, a, 1'b0)); end
    for (int a = 0; a < NumWords; a++) sb.push_back(mk(1'b0, a, 1'b0));
  endtask

  task automatic monitor_bus();
    op_t          e;
    logic [139:0] obs, exp_v;
    forever begin
      @(negedge clk);
      obs = {bist_en_o, bist_men_o, bist_wen_o, bist_ren_o, bist_addr_o, bist_din_o, bist_bm_o};
      checks++;
      if (bist_en_o || bist_men_o) begin
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL op_unexpected: got wen=%0b addr=%0h, expected no op", bist_wen_o, bist_addr_o);
        end else begin
          e = sb.pop_front();
          exp_v = {1'b1, 1'b1, e.wr, ~e.wr, e.addr, {DataWidth{e.one}}, {DataWidth{1'b1}}};
          if (obs !== exp_v) begin
            errors++;
            $display("FAIL op_seq: got %h, expected %h", obs, exp_v);
          end
        end
      end else if (obs !== '0) begin
        errors++;
        $display("FAIL bus_idle: got %h, expected 0", obs);
      end
    end
  endtask

  // Pulses (or holds) start_i and watches until done_o; collects timing stats.
  task automatic run_start(input bit hold, output int busy_cnt, output int done_cyc,
                           output int men_cnt, output int first_busy, output logic [4:0] k1);
    busy_cnt = 0; done_cyc = -1; men_cnt = 0; first_busy = -1; k1 = '1;
    @(negedge clk);
    start_i = 1'b1;
    for (int k = 1; k <= Budget; k++) begin
      @(negedge clk);
      if (!hold) start_i = 1'b0;
      if (k == 1) k1 = {busy_o, done_o, fail_o, err_cnt_o != 0, fail_addr_o != 0};
      if (busy_o) begin busy_cnt++; if (first_busy < 0) first_busy = k; end
      if (bist_men_o) men_cnt++;
      if (done_o) begin done_cyc = k; break; end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_i = 1'b1; start_i = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done_o); end
    checks++; if (fail_o !== 1'b0) begin errors++; $display("FAIL reset_fail: got %b expected 0", fail_o); end
    checks++; if (fail_addr_o !== '0) begin errors++; $display("FAIL reset_fail_addr: got %h expected 0", fail_addr_o); end
    checks++; if (err_cnt_o !== '0) begin errors++; $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt_o); end
    rst_i = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL idle_no_start: got busy %b expected 0", busy_o); end
  endtask

  task automatic test_clean(input bit hold);
    int bc, dc, mc, fb; logic [4:0] k1;
    fault_mode = 0;
    build_sb();
    run_start(hold, bc, dc, mc, fb, k1);
    checks++; if (k1 !== 5'b10000) begin errors++; $display("FAIL clean_first_cycle: got %b expected 10000", k1); end
    checks++; if (fb !== 1) begin errors++; $display("FAIL clean_first_busy: got %0d expected 1", fb); end
    checks++; if (bc !== RunCycles + 1) begin errors++; $display("FAIL clean_busy_cycles: got %0d expected %0d", bc, RunCycles + 1); end
    checks++; if (dc !== RunCycles + 2) begin errors++; $display("FAIL clean_done_cycle: got %0d expected %0d", dc, RunCycles + 2); end
    checks++; if (mc !== RunCycles) begin errors++; $display("FAIL clean_op_count: got %0d expected %0d", mc, RunCycles); end
    checks++; if (fail_o !== 1'b0 || err_cnt_o !== '0) begin errors++; $display("FAIL clean_status: got fail=%b err=%0d expected 0/0", fail_o, err_cnt_o); end
    checks++; if (sb.size() !== 0) begin errors++; $display("FAIL clean_ops_left: got %0d expected 0", sb.size()); end
    @(negedge clk);
    // start_i may still be high here when hold=1: DONE must have ignored it.
    checks++; if (busy_o !== 1'b0 || done_o !== 1'b1) begin errors++; $display("FAIL clean_after_done: got busy=%b done=%b expected 0/1", busy_o, done_o); end
    start_i = 1'b0;
    @(negedge clk);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL clean_no_restart: got busy=%b expected 0", busy_o); end
  endtask

  task automatic test_stuck_at0();
    int bc, dc, mc, fb; logic [4:0] k1;
    fault_mode = 1;
    build_sb();
    run_start(1'b0, bc, dc, mc, fb, k1);
    // Failing r1 is op 805 (E0 256 + E1 512 + 2*0x12 + 1); one write follows.
    checks++; if (mc !== 806) begin errors++; $display("FAIL sa0_op_count: got %0d expected 806", mc); end
    checks++; if (dc !== 808) begin errors++; $display("FAIL sa0_done_cycle: got %0d expected 808", dc); end
    checks++; if (fail_o !== 1'b1) begin errors++; $display("FAIL sa0_fail: got %b expected 1", fail_o); end
    checks++; if (fail_addr_o !== 8'h12) begin errors++; $display("FAIL sa0_fail_addr: got %h expected 12", fail_addr_o); end
    checks++; if (err_cnt_o !== 16'd1) begin errors++; $display("FAIL sa0_err_cnt: got %0d expected 1", err_cnt_o); end
    repeat (3) @(negedge clk);
    checks++; if (sb.size() !== RunCycles - 806) begin errors++; $display("FAIL sa0_ops_left: got %0d expected %0d", sb.size(), RunCycles - 806); end
    sb.delete();
  endtask

  task automatic test_restart_after_fail();
    int bc, dc, mc, fb; logic [4:0] k1;
    fault_mode = 0;
    build_sb();
    run_start(1'b0, bc, dc, mc, fb, k1);
    checks++; if (k1 !== 5'b10000) begin errors++; $display("FAIL restart_clears: got %b expected 10000", k1); end
    checks++; if (dc !== RunCycles + 2) begin errors++; $display("FAIL restart_done_cycle: got %0d expected %0d", dc, RunCycles + 2); end
    checks++; if (fail_o !== 1'b0) begin errors++; $display("FAIL restart_fail: got %b expected 0", fail_o); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_coupling();
    int bc, dc, mc, fb; logic [4:0] k1;
    fault_mode = 2;
    build_sb();
    run_start(1'b0, bc, dc, mc, fb, k1);
    checks++; if (dc < 0 || dc > RunCycles + 2) begin errors++; $display("FAIL cpl_done: got cycle %0d expected within run", dc); end
    checks++; if (fail_o !== 1'b1) begin errors++; $display("FAIL cpl_fail: got %b expected 1", fail_o); end
    checks++; if (fail_addr_o !== 8'h3F) begin errors++; $display("FAIL cpl_fail_addr: got %h expected 3f", fail_addr_o); end
    repeat (3) @(negedge clk);
    sb.delete();
  endtask

  task automatic test_reset_mid_run();
    fault_mode = 0;
    build_sb();
    @(negedge clk);
    start_i = 1'b1;
    for (int k = 1; k <= 700; k++) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL rst_mid_busy_before: got %b expected 1", busy_o); end
    #2 rst_i = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy_o, done_o, fail_o, fail_addr_o, err_cnt_o, bist_men_o, bist_en_o, bist_wen_o, bist_ren_o} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got busy=%b done=%b fail=%b men=%b expected all 0", busy_o, done_o, fail_o, bist_men_o);
    end
    sb.delete();
    @(negedge clk);
    rst_i = 1'b0;
    test_clean(1'b0);
  endtask

  task automatic test_sa1_two_words();
    int bc, dc, mc, fb; logic [4:0] k1;
    fault_mode = 3;
    build_sb();
    run_start(1'b0, bc, dc, mc, fb, k1);
`ifdef IHP13_SRAM_BIST_DIAG_EN
    checks++; if (dc !== RunCycles + 2) begin errors++; $display("FAIL diag_done_cycle: got %0d expected %0d", dc, RunCycles + 2); end
    checks++; if (bc !== RunCycles + 1) begin errors++; $display("FAIL diag_busy_cycles: got %0d expected %0d", bc, RunCycles + 1); end
    checks++; if (err_cnt_o !== 16'd6) begin errors++; $display("FAIL diag_err_cnt: got %0d expected 6", err_cnt_o); end
    checks++; if (fail_addr_o !== 8'h00) begin errors++; $display("FAIL diag_fail_addr: got %h expected 00", fail_addr_o); end
    checks++; if (fail_o !== 1'b1) begin errors++; $display("FAIL diag_fail: got %b expected 1", fail_o); end
`else
    // First E1 r0 at 0x00 is op 257; one write follows.
    checks++; if (mc !== 258) begin errors++; $display("FAIL sa1_op_count: got %0d expected 258", mc); end
    checks++; if (dc !== 260) begin errors++; $display("FAIL sa1_done_cycle: got %0d expected 260", dc); end
    checks++; if (err_cnt_o !== 16'd1) begin errors++; $display("FAIL sa1_err_cnt: got %0d expected 1", err_cnt_o); end
    checks++; if (fail_addr_o !== 8'h00) begin errors++; $display("FAIL sa1_fail_addr: got %h expected 00", fail_addr_o); end
    checks++; if (fail_o !== 1'b1) begin errors++; $display("FAIL sa1_fail: got %b expected 1", fail_o); end
`endif
    repeat (3) @(negedge clk);
    sb.delete();
  endtask

  initial begin
    rst_i   = 1'b1;
    start_i = 1'b0;
    fork
      monitor_bus();
    join_none
    test_reset();
    test_clean(1'b0);
    test_stuck_at0();
    test_restart_after_fail();
    test_coupling();
    test_reset_mid_run();
    test_clean(1'b1);
    test_sa1_two_words();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
